note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/seq_pkg.sv | 16 +
 rtl/note_table.sv | 22 ++
 rtl/note_sequencer.sv | 123 ++++++++++++
 tb/tb_note_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encoding and default sizes for the note sequencer.
// GAP exists only when SEQ_GAP_EN is defined.
package seq_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_FREQ_WIDTH = 8;
  localparam int DEF_DUR_WIDTH = 16;
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
`ifdef SEQ_GAP_EN
    GAP,
`endif
    FIN
  } state_t;
endpackage

// File: rtl/note_table.sv
// note_table: DEPTH-entry register file, one synchronous write port, one combinational read port.
module note_table
  import seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_FREQ_WIDTH + DEF_DUR_WIDTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a table of (frequency, duration) notes with optional looping.
// Define SEQ_GAP_EN to insert GAP_CYCLES silent cycles between notes.
module note_sequencer
  import seq_pkg::*;
#(
  parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
  parameter int DUR_WIDTH = DEF_DUR_WIDTH,
`ifdef SEQ_GAP_EN
  parameter int GAP_CYCLES = 4,
`endif
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [FREQ_WIDTH-1:0] wr_freq,
  input  logic [DUR_WIDTH-1:0]  wr_dur,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  output logic [FREQ_WIDTH-1:0] frequency_control,
  output logic                  gate,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] note_index
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] idx_n;
  logic [ADDR_WIDTH:0] len_q, len_n;
  logic [DUR_WIDTH-1:0] cnt, cnt_n, rd_dur;
  logic [FREQ_WIDTH-1:0] fc_n, rd_freq;
  logic gate_n, done_n, last;
  note_table #(.DEPTH(DEPTH), .WIDTH(FREQ_WIDTH + DUR_WIDTH)) u_table (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data({wr_freq, wr_dur}),
    .rd_addr(note_index),
    .rd_data({rd_freq, rd_dur})
  );
  assign last = {1'b0, note_index} >= len_q - 1'b1;
  always_comb begin
    state_n = state;
    idx_n = note_index;
    len_n = len_q;
    cnt_n = cnt;
    fc_n = frequency_control;
    gate_n = gate;
    done_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      gate_n = 1'b0;
      fc_n = '0;
    end else begin
      case (state)
        IDLE: if (start && length != '0) begin
          state_n = FETCH;
          len_n = length;
          idx_n = '0;
        end
        FETCH: begin
          state_n = PLAY;
          cnt_n = rd_dur == '0 ? DUR_WIDTH'(1) : rd_dur;
          fc_n = rd_freq;
          gate_n = rd_freq != '0;
        end
        PLAY: if (cnt == DUR_WIDTH'(1)) begin
          gate_n = 1'b0;
          if (!last || loop) begin
            idx_n = last ? '0 : note_index + 1'b1;
`ifdef SEQ_GAP_EN
            state_n = GAP;
            cnt_n = DUR_WIDTH'(GAP_CYCLES);
`else
            state_n = FETCH;
`endif
          end else begin
            state_n = FIN;
            fc_n = '0;
          end
        end else cnt_n = cnt - 1'b1;
`ifdef SEQ_GAP_EN
        GAP: begin
          state_n = cnt == DUR_WIDTH'(1) ? FETCH : GAP;
          cnt_n = cnt - 1'b1;
        end
`endif
        FIN: begin
          state_n = IDLE;
          done_n = 1'b1;
          gate_n = 1'b0;
          fc_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      note_index <= '0;
      len_q <= '0;
      cnt <= '0;
      frequency_control <= '0;
      gate <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      note_index <= idx_n;
      len_q <= len_n;
      cnt <= cnt_n;
      frequency_control <= fc_n;
      gate <= gate_n;
      busy <= state_n != IDLE;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of playback timing, looping, rests, stop and reset.
module tb_note_sequencer;
  logic clk = 0, reset = 1, wr_en = 0, start = 0, stop = 0, loop = 0;
  logic [2:0] wr_addr = 0;
  logic [7:0] wr_freq = 0;
  logic [15:0] wr_dur = 0;
  logic [3:0] length = 0;
  logic [7:0] frequency_control;
  logic gate, busy, done;
  logic [2:0] note_index;
  int n_cmp = 0, n_err = 0;
  note_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq),
    .wr_dur(wr_dur), .length(length), .start(start), .stop(stop), .loop(loop),
    .frequency_control(frequency_control), .gate(gate), .busy(busy), .done(done),
    .note_index(note_index)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] f, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_freq = f; wr_dur = d;
    tick();
    wr_en = 0;
  endtask
  task automatic go(input logic [3:0] len);
    length = len; start = 1;
    tick();
    start = 0;
  endtask
  task automatic zero_outs(input string tag);
    chk({tag, ".fc"}, 32'(frequency_control), 0);
    chk({tag, ".gate"}, 32'(gate), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".idx"}, 32'(note_index), 0);
  endtask
  int eg [1:9] = '{0, 1, 1, 1, 0, 1, 1, 0, 0};
  int ef [1:9] = '{0, 32, 32, 32, 32, 64, 64, 0, 0};
  int eb [1:9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  int ed [1:9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  int ei [1:8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int dc;
  initial begin
    tick(); tick();
    zero_outs("reset");
    reset = 0;
    wr(0, 32, 3);
    wr(1, 64, 2);
    go(2);
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("play.gate@%0d", c), 32'(gate), eg[c]);
      chk($sformatf("play.fc@%0d", c), 32'(frequency_control), ef[c]);
      chk($sformatf("play.busy@%0d", c), 32'(busy), eb[c]);
      chk($sformatf("play.done@%0d", c), 32'(done), ed[c]);
      if (c <= 8) chk($sformatf("play.idx@%0d", c), 32'(note_index), ei[c]);
      tick();
    end
    chk("play.done_after", 32'(done), 0);
    loop = 1;
    go(2);
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("loop.done@%0d", c), 32'(done), 0);
      if (c inside {3, 10, 17}) chk($sformatf("loop.idx@%0d", c), 32'(note_index), 0);
      if (c inside {6, 13, 20}) chk($sformatf("loop.idx@%0d", c), 32'(note_index), 1);
      tick();
    end
    loop = 0;
    dc = -1;
    for (int c = 21; c < 40; c++) begin
      if (done && dc < 0) dc = c;
      tick();
    end
    chk("loop.done_cycle", 32'(dc), 23);
    wr(0, 0, 5);
    go(1);
    tick();
    for (int c = 2; c <= 6; c++) begin
      chk($sformatf("rest.gate@%0d", c), 32'(gate), 0);
      chk($sformatf("rest.fc@%0d", c), 32'(frequency_control), 0);
      chk($sformatf("rest.busy@%0d", c), 32'(busy), 1);
      tick();
    end
    chk("rest.fin_busy", 32'(busy), 1);
    chk("rest.fin_done", 32'(done), 0);
    tick();
    chk("rest.done", 32'(done), 1);
    wr(0, 32, 3);
    go(2);
    repeat (5) tick();
    chk("stop.pre_gate", 32'(gate), 1);
    chk("stop.pre_idx", 32'(note_index), 1);
    stop = 1;
    tick();
    stop = 0;
    chk("stop.busy", 32'(busy), 0);
    chk("stop.gate", 32'(gate), 0);
    chk("stop.fc", 32'(frequency_control), 0);
    chk("stop.done", 32'(done), 0);
    repeat (3) tick();
    chk("stop.no_done", 32'(done), 0);
    chk("stop.idle", 32'(busy), 0);
    stop = 1; length = 2; start = 1;
    tick();
    stop = 0; start = 0;
    chk("startstop.busy", 32'(busy), 0);
    tick();
    chk("startstop.busy2", 32'(busy), 0);
    go(0);
    chk("len0.busy", 32'(busy), 0);
    tick();
    chk("len0.gate", 32'(gate), 0);
    wr(0, 16, 0);
    go(1);
    tick();
    chk("dur0.gate", 32'(gate), 1);
    chk("dur0.fc", 32'(frequency_control), 16);
    tick();
    chk("dur0.fin_gate", 32'(gate), 0);
    chk("dur0.fin_busy", 32'(busy), 1);
    tick();
    chk("dur0.done", 32'(done), 1);
    wr(0, 32, 3);
    go(1);
    tick(); tick();
    chk("rst.pre_gate", 32'(gate), 1);
    reset = 1; start = 1; wr_en = 1; wr_addr = 0; wr_freq = 99; wr_dur = 9;
    tick();
    reset = 0; start = 0; wr_en = 0;
    zero_outs("rst_mid");
    go(1);
    tick();
    chk("cleared.gate", 32'(gate), 0);
    chk("cleared.fc", 32'(frequency_control), 0);
    chk("cleared.busy", 32'(busy), 1);
    tick(); tick();
    chk("cleared.done", 32'(done), 1);
    wr(0, 48, 1);
    go(1);
    wr_en = 1; wr_addr = 0; wr_freq = 80; wr_dur = 1;
    tick();
    wr_en = 0;
    chk("wrfetch.old", 32'(frequency_control), 48);
    tick(); tick();
    chk("wrfetch.done", 32'(done), 1);
    go(1);
    tick();
    chk("wrfetch.new", 32'(frequency_control), 80);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
